vec_result_checker: RTL and testbench

Synthesizable, parametrised result checker for on-FPGA self-test of the `Tile` vector core. It replaces the simulation-only check-and-timeout loop with hardware:
- A queue of expected results (source, register/word address, data) is pushed in.
- The block snoops write ports of the scalar RF, vector RF and DMEM.
- It retires each expectation as pass or fail with a per-check cycle timeout.
- Results are exposed as counters and flags readable over the debug path.

---
 rtl/vec_result_checker.sv | 198 +++++++++++++++++++
 tb/tb_vec_result_checker.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_result_checker.sv
// vec_result_checker: on-FPGA self-test checker for the Tile vector core.
// Queues expectations, snoops RF/VRF/DMEM writes, retires pass or fail.
module vec_result_checker #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_SRC      = 3,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT      = 20,
  parameter int STOP_ON_FAIL = 1,
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          exp_valid,
  output logic                          exp_ready,
  input  logic [SRC_W-1:0]              exp_src,
  input  logic [ADDR_WIDTH-1:0]         exp_addr,
  input  logic [DATA_WIDTH-1:0]         exp_data,
  input  logic                          exp_last,
  input  logic [NUM_SRC-1:0]            mon_valid,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] mon_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] mon_data,
  output logic                          check_pass,
  output logic                          check_fail,
  output logic                          busy,
  output logic                          done,
  output logic                          all_passed,
  output logic                          halted,
  output logic [15:0]                   test_id,
  output logic [15:0]                   pass_count,
  output logic [15:0]                   fail_count,
  output logic [15:0]                   fail_id,
  output logic [DATA_WIDTH-1:0]         last_seen
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam bit STOP   = (STOP_ON_FAIL != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_RETIRE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [SRC_W-1:0]      fifo_src  [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic                  fifo_last [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [2:0]            state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [SRC_W-1:0]      cur_src;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  cur_last;

  logic                  push;
  logic                  pop;
  logic                  sel_v;
  logic [ADDR_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_d;
  logic                  hit_addr;
  logic                  match;
  logic                  timeout;

  assign exp_ready  = (count != CNT_W'(DEPTH)) && !done && !halted;
  assign push       = exp_valid && exp_ready;
  assign pop        = (count != '0)
                   && ((state == S_IDLE)
                    || (state == S_RETIRE && !cur_last));
  assign busy       = (state == S_ARMED) || (count != '0);
  assign all_passed = done && (fail_count == 16'd0) && !halted;
  assign timeout    = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Select the monitored port named by the armed check; bad src never hits.
  always_comb begin
    sel_v = 1'b0;
    sel_a = '0;
    sel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_src == SRC_W'(i)) begin
        sel_v = mon_valid[i];
        sel_a = mon_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_d = mon_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    hit_addr = sel_v && (sel_a == cur_addr);
    match    = hit_addr && (sel_d == cur_data);
  end

  // Expectation storage; no reset needed, validity tracked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_src[wr_ptr]  <= exp_src;
      fifo_addr[wr_ptr] <= exp_addr;
      fifo_data[wr_ptr] <= exp_data;
      fifo_last[wr_ptr] <= exp_last;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Check sequencer: arm, wait for match or timeout, retire, record.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      cur_src    <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      cur_last   <= 1'b0;
      check_pass <= 1'b0;
      check_fail <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      test_id    <= '0;
      pass_count <= '0;
      fail_count <= '0;
      fail_id    <= '0;
      last_seen  <= '0;
    end else begin
      check_pass <= 1'b0;
      check_fail <= 1'b0;
      if (pop) begin
        cur_src  <= fifo_src[rd_ptr];
        cur_addr <= fifo_addr[rd_ptr];
        cur_data <= fifo_data[rd_ptr];
        cur_last <= fifo_last[rd_ptr];
        test_id  <= test_id + 16'd1;
        wait_cnt <= '0;
      end
      unique case (state)
        S_IDLE: begin
          if (pop) state <= S_ARMED;
        end
        S_ARMED: begin
          if (match) begin
            check_pass <= 1'b1;
            if (pass_count != 16'hFFFF)
              pass_count <= pass_count + 16'd1;
            state <= S_RETIRE;
          end else if (timeout) begin
            check_fail <= 1'b1;
            if (fail_count != 16'hFFFF)
              fail_count <= fail_count + 16'd1;
            if (fail_count == 16'd0)
              fail_id <= test_id;
            if (STOP) begin
              state  <= S_HALT;
              halted <= 1'b1;
              done   <= 1'b1;
            end else begin
              state <= S_RETIRE;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (hit_addr) last_seen <= sel_d;
          end
        end
        S_RETIRE: begin
          if (cur_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (pop) begin
            state <= S_ARMED;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE:  state <= S_DONE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_result_checker.sv
// tb_vec_result_checker: vector table plus scoreboard for the checker.
// Second instance runs with STOP_ON_FAIL=0 for continue mode.
module tb_vec_result_checker;

  logic         clock;
  logic         reset;
  logic         exp_valid;
  logic [1:0]   exp_src;
  logic [11:0]  exp_addr;
  logic [255:0] exp_data;
  logic         exp_last;
  logic [2:0]   mon_valid;
  logic [35:0]  mon_addr;
  logic [767:0] mon_data;

  logic         exp_ready, check_pass, check_fail, busy, done;
  logic         all_passed, halted;
  logic [15:0]  test_id, pass_count, fail_count, fail_id;
  logic [255:0] last_seen;

  logic         c_exp_ready, c_check_pass, c_check_fail, c_busy, c_done;
  logic         c_all_passed, c_halted;
  logic [15:0]  c_test_id, c_pass_count, c_fail_count, c_fail_id;
  logic [255:0] c_last_seen;

  vec_result_checker #(.STOP_ON_FAIL(1)) dut (
    .clock(clock), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_src(exp_src), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_last(exp_last),
    .mon_valid(mon_valid), .mon_addr(mon_addr),
    .mon_data(mon_data),
    .check_pass(check_pass), .check_fail(check_fail),
    .busy(busy), .done(done), .all_passed(all_passed),
    .halted(halted), .test_id(test_id),
    .pass_count(pass_count), .fail_count(fail_count),
    .fail_id(fail_id), .last_seen(last_seen)
  );

  vec_result_checker #(.STOP_ON_FAIL(0)) dut_c (
    .clock(clock), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(c_exp_ready),
    .exp_src(exp_src), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_last(exp_last),
    .mon_valid(mon_valid), .mon_addr(mon_addr),
    .mon_data(mon_data),
    .check_pass(c_check_pass), .check_fail(c_check_fail),
    .busy(c_busy), .done(c_done), .all_passed(c_all_passed),
    .halted(c_halted), .test_id(c_test_id),
    .pass_count(c_pass_count), .fail_count(c_fail_count),
    .fail_id(c_fail_id), .last_seen(c_last_seen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit pass;
    int id;
  } sb_t;

  typedef struct {
    logic [1:0]   src;
    logic [11:0]  addr;
    logic [255:0] data;
    int           delay;
    int           wsrc;
    logic [11:0]  waddr;
    logic [255:0] wdata;
    bit           pass;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[9];
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;
  bit   sb_sel = 1'b0;

  // Scoreboard: every retire pulse must match the oldest expected outcome.
  always @(negedge clock) begin
    logic        p, f;
    logic [15:0] id;
    sb_t         e;
    p  = sb_sel ? c_check_pass : check_pass;
    f  = sb_sel ? c_check_fail : check_fail;
    id = sb_sel ? c_test_id : test_id;
    if (p || f) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected pass=%0b fail=%0b id=%0d",
                 p, f, id);
      end else begin
        e = sb.pop_front();
        if (p !== e.pass || f === p || id !== 16'(e.id)) begin
          errors++;
          $display("FAIL sb_retire got pass=%0b fail=%0b id=%0d want pass=%0b id=%0d",
                   p, f, id, e.pass, e.id);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    exp_valid = 1'b0;
    exp_src   = '0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_last  = 1'b0;
    mon_valid = '0;
    mon_addr  = '0;
    mon_data  = '0;
    repeat (2) @(negedge clock);
    sb.delete();
    next_id = 0;
    reset   = 1'b0;
  endtask

  task automatic push(input logic [1:0] s, input logic [11:0] a,
                      input logic [255:0] d, input bit last,
                      input bit pass);
    int  n;
    sb_t e;
    exp_valid = 1'b1;
    exp_src   = s;
    exp_addr  = a;
    exp_data  = d;
    exp_last  = last;
    n = 0;
    while (!exp_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!exp_ready) begin
      checks++;
      errors++;
      $display("FAIL push_ready_timeout got=0 want=1");
    end
    @(negedge clock);
    exp_valid = 1'b0;
    next_id++;
    e.pass = pass;
    e.id   = next_id;
    sb.push_back(e);
  endtask

  task automatic wr(input int s, input logic [11:0] a,
                    input logic [255:0] d);
    mon_valid = 3'(1 << s);
    mon_addr[s*12 +: 12]   = a;
    mon_data[s*256 +: 256] = d;
    @(negedge clock);
    mon_valid = '0;
  endtask

  task automatic wait_sb(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_retired"}, 256'(sb.size()), 256'd0);
  endtask

  localparam logic [255:0] D8 = {8{32'h42C80000}};

  initial begin
    int n;
    logic [255:0] d;

    vt[0] = '{2'd1, 12'd3,  D8,              5, 1, 12'd3,  D8,              1'b1};
    vt[1] = '{2'd0, 12'd5,  256'h1F5,       -1, 0, 12'd5,  256'h1F5,        1'b0};
    vt[2] = '{2'd2, 12'h40, 256'h12345670,   0, 2, 12'h40, 256'h12345670,   1'b0};
    vt[3] = '{2'd2, 12'h40, 256'h12345670,   1, 2, 12'h40, 256'h12345670,   1'b1};
    vt[4] = '{2'd2, 12'h40, 256'h12345670,  20, 2, 12'h40, 256'h12345670,   1'b1};
    vt[5] = '{2'd2, 12'h40, 256'h12345670,  21, 2, 12'h40, 256'h12345670,   1'b0};
    vt[6] = '{2'd1, 12'd7,  256'hABCD,       3, 1, 12'd8,  256'hABCD,       1'b0};
    vt[7] = '{2'd0, 12'd7,  256'hABCD,       3, 1, 12'd7,  256'hABCD,       1'b0};
    vt[8] = '{2'd3, 12'd7,  256'hABCD,       3, 0, 12'd7,  256'hABCD,       1'b0};

    // reset state
    do_reset();
    chk("rst_exp_ready",  256'(exp_ready),  256'd1);
    chk("rst_busy",       256'(busy),       256'd0);
    chk("rst_done",       256'(done),       256'd0);
    chk("rst_all_passed", 256'(all_passed), 256'd0);
    chk("rst_halted",     256'(halted),     256'd0);
    chk("rst_test_id",    256'(test_id),    256'd0);
    chk("rst_pass_count", 256'(pass_count), 256'd0);
    chk("rst_fail_count", 256'(fail_count), 256'd0);
    chk("rst_fail_id",    256'(fail_id),    256'd0);
    chk("rst_last_seen",  last_seen,        256'd0);

    // single-check vectors
    for (int i = 0; i < 9; i++) begin
      do_reset();
      push(vt[i].src, vt[i].addr, vt[i].data, 1'b1, vt[i].pass);
      if (vt[i].delay >= 0) begin
        repeat (vt[i].delay) @(negedge clock);
        wr(vt[i].wsrc, vt[i].waddr, vt[i].wdata);
      end
      wait_sb($sformatf("v%0d", i));
      chk($sformatf("v%0d_pass_count", i), 256'(pass_count),
          vt[i].pass ? 256'd1 : 256'd0);
      chk($sformatf("v%0d_fail_count", i), 256'(fail_count),
          vt[i].pass ? 256'd0 : 256'd1);
      chk($sformatf("v%0d_done", i), 256'(done), 256'd1);
      chk($sformatf("v%0d_all_passed", i), 256'(all_passed),
          vt[i].pass ? 256'd1 : 256'd0);
      chk($sformatf("v%0d_halted", i), 256'(halted),
          vt[i].pass ? 256'd0 : 256'd1);
      chk($sformatf("v%0d_fail_id", i), 256'(fail_id),
          vt[i].pass ? 256'd0 : 256'd1);
    end

    // timeout lands TIMEOUT cycles after the arming edge
    do_reset();
    push(2'd0, 12'd5, 256'h1F5, 1'b1, 1'b0);
    n = 0;
    while (!check_fail && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_cycles", 256'(n), 256'd21);
    chk("timeout_fail_id", 256'(fail_id), 256'd1);
    chk("timeout_halted", 256'(halted), 256'd1);
    wait_sb("timeout");

    // wrong data then right data on DMEM 0x40
    do_reset();
    push(2'd2, 12'h40, 256'h12345670, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    wr(2, 12'h40, 256'hDEADBEEF);
    chk("wtr_last_seen_wrong", last_seen, 256'hDEADBEEF);
    chk("wtr_no_pass_yet", 256'(check_pass), 256'd0);
    wr(2, 12'h40, 256'h12345670);
    chk("wtr_pass_pulse", 256'(check_pass), 256'd1);
    @(negedge clock);
    chk("wtr_pulse_one_cycle", 256'(check_pass), 256'd0);
    wait_sb("wtr");
    chk("wtr_fail_count", 256'(fail_count), 256'd0);
    chk("wtr_pass_count", 256'(pass_count), 256'd1);
    chk("wtr_last_seen_kept", last_seen, 256'hDEADBEEF);
    chk("wtr_all_passed", 256'(all_passed), 256'd1);

    // fill the FIFO, then satisfy in order
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d = 256'(i * 32'h11110001 + 7);
      push(2'd1, 12'(10 + i), d, i == 8, 1'b1);
    end
    chk("full_exp_ready_low", 256'(exp_ready), 256'd0);
    chk("full_busy", 256'(busy), 256'd1);
    for (int i = 0; i < 9; i++) begin
      d = 256'(i * 32'h11110001 + 7);
      wr(1, 12'(10 + i), d);
      if (i == 0)
        chk("full_ready_before_pop", 256'(exp_ready), 256'd0);
      @(negedge clock);
      if (i == 0)
        chk("full_ready_after_pop", 256'(exp_ready), 256'd1);
    end
    wait_sb("full");
    chk("full_pass_count", 256'(pass_count), 256'd9);
    chk("full_test_id", 256'(test_id), 256'd9);
    chk("full_done", 256'(done), 256'd1);
    chk("full_fail_count", 256'(fail_count), 256'd0);

    // continue mode: second check times out, third still runs
    do_reset();
    sb_sel = 1'b1;
    push(2'd0, 12'd1, 256'h111, 1'b0, 1'b1);
    push(2'd0, 12'd2, 256'h222, 1'b0, 1'b0);
    push(2'd0, 12'd3, 256'h333, 1'b1, 1'b1);
    wr(0, 12'd1, 256'h111);
    n = 0;
    while (!c_check_fail && n < 60) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    wr(0, 12'd3, 256'h333);
    wait_sb("cont");
    chk("cont_pass_count", 256'(c_pass_count), 256'd2);
    chk("cont_fail_count", 256'(c_fail_count), 256'd1);
    chk("cont_fail_id", 256'(c_fail_id), 256'd2);
    chk("cont_done", 256'(c_done), 256'd1);
    chk("cont_halted", 256'(c_halted), 256'd0);
    chk("cont_all_passed", 256'(c_all_passed), 256'd0);
    chk("cont_test_id", 256'(c_test_id), 256'd3);
    sb_sel = 1'b0;

    // reset asserted mid-check
    do_reset();
    push(2'd0, 12'd9, 256'h99, 1'b1, 1'b0);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sb.delete();
    reset = 1'b0;
    chk("rmid_check_fail", 256'(check_fail), 256'd0);
    chk("rmid_check_pass", 256'(check_pass), 256'd0);
    chk("rmid_test_id", 256'(test_id), 256'd0);
    chk("rmid_busy", 256'(busy), 256'd0);
    chk("rmid_exp_ready", 256'(exp_ready), 256'd1);
    repeat (30) @(negedge clock);
    chk("rmid_fail_count", 256'(fail_count), 256'd0);
    chk("rmid_pass_count", 256'(pass_count), 256'd0);
    chk("rmid_done", 256'(done), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
